// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event scheduler: event types, per-button
// FSM encoding and default timing for a 100 MHz clock.
package btn_evt_pkg;

  localparam logic EVT_PRESS  = 1'b0;
  localparam logic EVT_REPEAT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int HOLD_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_hold_timer.sv
// One button: rising-edge detect plus hold/repeat FSM. Emits a registered
// one-cycle req pulse with req_type PRESS or REPEAT.
module button_hold_timer
  import btn_evt_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic req,
  output logic req_type
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state;
  logic [CNT_W-1:0] timer;
  logic             prev;

  // Release is tested before expiry so a release on the expiry edge is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      prev     <= 1'b0;
      req      <= 1'b0;
      req_type <= EVT_PRESS;
    end else begin
      prev <= level;
      req  <= 1'b0;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (level && !prev) begin
            req      <= 1'b1;
            req_type <= EVT_PRESS;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!level) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer == HOLD_LAST) begin
            req      <= 1'b1;
            req_type <= EVT_REPEAT;
            timer    <= '0;
            state    <= REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!level) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer == REPEAT_LAST) begin
            req      <= 1'b1;
            req_type <= EVT_REPEAT;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// N debounced buttons -> PRESS/REPEAT events, coalesced in a per-button
// pending store and round-robin arbitrated onto one registered valid/ready stream.
module button_event_scheduler #(
  parameter  int N_BTN         = 5,
  parameter  int HOLD_CYCLES   = btn_evt_pkg::HOLD_CYCLES_DEF,
  parameter  int REPEAT_CYCLES = btn_evt_pkg::REPEAT_CYCLES_DEF,
  localparam int CNT_W = $clog2(btn_evt_pkg::max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1),
  localparam int ID_W  = btn_evt_pkg::max_int(1, $clog2(N_BTN))
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_STATE,
  input  logic             EVT_READY,
  output logic             EVT_VALID,
  output logic [ID_W-1:0]  EVT_ID,
  output logic             EVT_REPEAT,
  output logic [N_BTN-1:0] PENDING,
  output logic             OVERRUN
);

  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] req_type;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] ptype;
  logic [N_BTN-1:0] gnt_vec;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  sel;
  logic             found;
  logic             load;
  logic             grant;
  int               idx;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_hold_timer #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .level   (BTN_STATE[i]),
      .req     (req[i]),
      .req_type(req_type[i])
    );
  end

  // First pending button at or above rr_ptr, wrapping back to 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  assign load  = !EVT_VALID || EVT_READY;
  assign grant = load && found;

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[sel] = 1'b1;
  end

  // Set beats a same-cycle grant; a REPEAT never downgrades a waiting PRESS.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend    <= '0;
      ptype   <= '0;
      OVERRUN <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (req[i]) begin
          if (pend[i] && !gnt_vec[i]) begin
            OVERRUN <= 1'b1;
            if (req_type[i] == btn_evt_pkg::EVT_PRESS) ptype[i] <= btn_evt_pkg::EVT_PRESS;
          end else begin
            pend[i]  <= 1'b1;
            ptype[i] <= req_type[i];
          end
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      EVT_VALID  <= 1'b0;
      EVT_ID     <= '0;
      EVT_REPEAT <= 1'b0;
      rr_ptr     <= '0;
    end else if (load) begin
      EVT_VALID <= found;
      if (found) begin
        EVT_ID     <= sel;
        EVT_REPEAT <= ptype[sel];
        rr_ptr     <= (sel == ID_W'(N_BTN - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  assign PENDING = pend;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with an age-based event model
// compared every cycle, plus literal expectations per scenario.
module tb_button_event_scheduler;

  localparam int N  = 5;
  localparam int H  = 8;
  localparam int R  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn;
  logic          ready;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_repeat;
  logic [N-1:0]  pending;
  logic          overrun;

  button_event_scheduler #(.N_BTN(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .CLK(clk), .RST(rst), .BTN_STATE(btn), .EVT_READY(ready),
    .EVT_VALID(evt_valid), .EVT_ID(evt_id), .EVT_REPEAT(evt_repeat),
    .PENDING(pending), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: presses tracked by start cycle, requests delayed one edge.
  bit         held [N];
  int         press_cyc [N];
  bit         mprev [N];
  bit         mreq [N];
  bit         mreq_rep [N];
  bit [N-1:0] mpend;
  bit [N-1:0] mptype;
  bit         mvalid;
  int         mid;
  bit         mrep;
  int         mrr;
  bit         movr;
  int         m_sel;
  int         m_age;
  int         m_j;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        held[i] = 0; mprev[i] = 0; mreq[i] = 0; mreq_rep[i] = 0;
      end
      mpend = '0; mptype = '0; mvalid = 0; mid = 0; mrep = 0; mrr = 0; movr = 0;
    end else begin
      m_sel = -1;
      if (!mvalid || ready) begin
        for (int k = 0; k < N; k++) begin
          m_j = (mrr + k) % N;
          if (m_sel < 0 && mpend[m_j]) m_sel = m_j;
        end
        if (m_sel >= 0) begin
          mvalid = 1; mid = m_sel; mrep = mptype[m_sel]; mrr = (m_sel + 1) % N;
        end else begin
          mvalid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (mreq[i]) begin
          if (mpend[i] && m_sel != i) begin
            movr = 1;
            if (!mreq_rep[i]) mptype[i] = 0;
          end else begin
            mpend[i] = 1; mptype[i] = mreq_rep[i];
          end
        end else if (m_sel == i) begin
          mpend[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        mreq[i] = 0;
        if (!btn[i]) begin
          held[i] = 0;
        end else if (held[i]) begin
          m_age = cyc - press_cyc[i];
          if (m_age == H || (m_age > H && (m_age - H) % R == 0)) begin
            mreq[i] = 1; mreq_rep[i] = 1;
          end
        end else if (!mprev[i]) begin
          held[i] = 1; press_cyc[i] = cyc; mreq[i] = 1; mreq_rep[i] = 0;
        end
        mprev[i] = btn[i];
      end
    end
  end

  typedef struct { int c; int id; bit rep; } evt_t;
  evt_t evq[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", evt_valid, mvalid);
      if (mvalid) begin
        check("id", evt_id, mid);
        check("type", evt_repeat, mrep);
      end
      check("pending", pending, mpend);
      check("overrun", overrun, movr);
      if (evt_valid === 1'b1 && ready === 1'b1)
        evq.push_back('{cyc, int'(evt_id), evt_repeat});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int base;
  int k0;
  int n1;
  int n3;

  initial begin
    rst = 1'b1; btn = 5'b11111; ready = 1'b1;

    // Reset held 3 cycles with every button down.
    step(1);
    cmp_en = 1'b1;
    step(2);
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_type", evt_repeat, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    btn = '0;
    step(1);
    rst = 1'b0;
    base = evq.size();
    step(5);
    check("t1_no_evt", evq.size() - base, 0);

    // Single tap on button 2.
    base = evq.size();
    k0 = cyc;
    btn[2] = 1'b1;
    step(3);
    btn[2] = 1'b0;
    step(6);
    check("t2_count", evq.size() - base, 1);
    if (evq.size() - base == 1) begin
      check("t2_id", evq[base].id, 2);
      check("t2_type", evq[base].rep, 0);
      check("t2_latency", evq[base].c, k0 + 3);
    end

    // Long hold on button 0: PRESS, REPEAT after 8, then every 4.
    base = evq.size();
    btn[0] = 1'b1;
    step(30);
    btn[0] = 1'b0;
    step(6);
    check("t3_count", evq.size() - base, 7);
    if (evq.size() - base == 7) begin
      check("t3_first_type", evq[base].rep, 0);
      check("t3_second_type", evq[base+1].rep, 1);
      check("t3_hold_gap", evq[base+1].c - evq[base].c, 8);
      check("t3_rep_gap", evq[base+2].c - evq[base+1].c, 4);
      check("t3_last_id", evq[base+6].id, 0);
    end

    // Release lands on the first-REPEAT-after-that expiry edge: no event.
    base = evq.size();
    btn[0] = 1'b1;
    step(12);
    btn[0] = 1'b0;
    step(6);
    check("t3b_count", evq.size() - base, 2);

    // Simultaneous presses with rr_ptr back at 0.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    base = evq.size();
    btn = 5'b10101;
    step(3);
    btn = '0;
    step(6);
    check("t4_count", evq.size() - base, 3);
    if (evq.size() - base == 3) begin
      check("t4_id0", evq[base].id, 0);
      check("t4_id1", evq[base+1].id, 2);
      check("t4_id2", evq[base+2].id, 4);
      check("t4_b2b", evq[base+2].c - evq[base].c, 2);
    end

    // Backpressure while button 1 repeats.
    base = evq.size();
    ready = 1'b0;
    btn[1] = 1'b1;
    step(20);
    check("t5_valid", evt_valid, 1);
    check("t5_id", evt_id, 1);
    check("t5_type", evt_repeat, 0);
    check("t5_overrun", overrun, 1);
    check("t5_pending", pending, 5'b00010);
    btn[1] = 1'b0;
    ready = 1'b1;
    step(5);
    check("t5_count", evq.size() - base, 2);
    if (evq.size() - base == 2) begin
      check("t5_ev0_type", evq[base].rep, 0);
      check("t5_ev1_id", evq[base+1].id, 1);
      check("t5_ev1_type", evq[base+1].rep, 1);
    end
    check("t5_overrun_sticky", overrun, 1);

    // Buttons 1 and 3 repeating together, then reset mid-stream.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    base = evq.size();
    btn = 5'b01010;
    step(30);
    rst = 1'b1;
    step(1);
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_pending", pending, 0);
    btn = '0;
    step(2);
    rst = 1'b0;
    step(3);
    n1 = 0;
    n3 = 0;
    for (int j = base; j < evq.size(); j++) begin
      if (evq[j].id == 1) n1++;
      if (evq[j].id == 3) n3++;
      if (j > base) check("t6_alternate", evq[j].id != evq[j-1].id, 1);
    end
    check("t6_total", n1 + n3, evq.size() - base);
    check("t6_id1_served", n1 >= 5, 1);
    check("t6_id3_served", n3 >= 5, 1);
    check("t6_balanced", (n1 - n3 <= 1) && (n3 - n1 <= 1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
